// File: rtl/ras_ctrl.sv
//==============================================================================
// Module   : ras_ctrl
// Purpose  : Return-address stack with branch checkpoints for next-PC selection.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ras_ctrl #(
  parameter int DEPTH = 10,
  parameter int AW    = 32,
  parameter int PTR_W = 4,
  parameter int NCKPT = 4
) (
  input  logic             fire,
  input  logic             i_rstN,
  input  logic             i_valid_1,
  output logic             o_ready_1,
  input  logic [2:0]       i_type_3,
  input  logic [AW-1:0]    i_pushAddr_32,
  input  logic             i_ckptAlloc_1,
  output logic [1:0]       o_ckptId_2,
  output logic             o_ckptFull_1,
  input  logic             i_restore_1,
  input  logic [1:0]       i_restoreId_2,
  input  logic             i_release_1,
  input  logic [1:0]       i_releaseId_2,
  output logic             o_retValid_1,
  output logic [AW-1:0]    o_retAddr_32,
  output logic             o_underflow_1,
  output logic             o_overflow_1,
  output logic [PTR_W-1:0] o_count_4
);

  localparam logic [2:0]       c_CALL  = 3'd4;
  localparam logic [2:0]       c_RET   = 3'd5;
  localparam logic [PTR_W-1:0] c_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] c_DEPTH = PTR_W'(DEPTH);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_RESTORE = 1'b1
  } state_t;

  state_t r_state, w_state_n;

  logic [AW-1:0]    r_stack   [DEPTH];
  logic [PTR_W-1:0] r_tos;
  logic [PTR_W-1:0] r_count;
  logic [NCKPT-1:0] r_used;
  logic [PTR_W-1:0] r_ck_tos   [NCKPT];
  logic [PTR_W-1:0] r_ck_count [NCKPT];
  logic [AW-1:0]    r_ck_top   [NCKPT];
  logic [AW-1:0]    r_fix_top;
  logic             r_ret_valid;
  logic [AW-1:0]    r_ret_addr;
  logic             r_underflow;
  logic             r_overflow;

  logic             w_is_call;
  logic             w_is_ret;
  logic             w_acc;
  logic             w_full;
  logic             w_do_restore;
  logic [1:0]       w_free_id;
  logic [PTR_W-1:0] w_tos_inc;
  logic [PTR_W-1:0] w_tos_dec;
  logic [PTR_W-1:0] w_tos_n;
  logic [PTR_W-1:0] w_count_n;
  logic [AW-1:0]    w_top_n;

  assign w_is_call    = (i_type_3 == c_CALL);
  assign w_is_ret     = (i_type_3 == c_RET);
  assign w_full       = &r_used;
  assign w_do_restore = (r_state == ST_RUN) && i_restore_1 && r_used[i_restoreId_2];
  assign o_ready_1    = i_rstN && (r_state == ST_RUN) && !i_restore_1 &&
                        !(i_ckptAlloc_1 && w_full);
  assign w_acc        = i_valid_1 && o_ready_1;
  assign w_tos_inc    = (r_tos == c_LAST) ? '0 : r_tos + 1'b1;
  assign w_tos_dec    = (r_tos == '0) ? c_LAST : r_tos - 1'b1;

  // Lowest free checkpoint slot wins.
  always_comb begin
    w_free_id = '0;
    for (int i = NCKPT - 1; i >= 0; i--) begin
      if (!r_used[i]) w_free_id = 2'(i);
    end
  end

  // Stack pointer/count/top as they will be after this cycle's request.
  always_comb begin
    w_tos_n   = r_tos;
    w_count_n = r_count;
    w_top_n   = r_stack[r_tos];
    if (w_is_call) begin
      w_tos_n   = w_tos_inc;
      w_count_n = (r_count == c_DEPTH) ? r_count : r_count + 1'b1;
      w_top_n   = i_pushAddr_32;
    end else if (w_is_ret && (r_count != '0)) begin
      w_tos_n   = w_tos_dec;
      w_count_n = r_count - 1'b1;
      w_top_n   = r_stack[w_tos_dec];
    end
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_RUN:     if (w_do_restore) w_state_n = ST_RESTORE;
      ST_RESTORE: w_state_n = ST_RUN;
      default:    w_state_n = ST_RUN;
    endcase
  end

  always_ff @(posedge fire) begin
    if (!i_rstN) r_state <= ST_RUN;
    else         r_state <= w_state_n;
  end

  always_ff @(posedge fire) begin
    if (!i_rstN) begin
      r_tos       <= '0;
      r_count     <= '0;
      r_used      <= '0;
      r_fix_top   <= '0;
      r_ret_valid <= 1'b0;
      r_ret_addr  <= '0;
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_ret_valid <= 1'b0;
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
      if (w_do_restore) begin
        r_tos     <= r_ck_tos[i_restoreId_2];
        r_count   <= r_ck_count[i_restoreId_2];
        r_fix_top <= r_ck_top[i_restoreId_2];
        r_used    <= '0;
      end else begin
        if (i_release_1) r_used[i_releaseId_2] <= 1'b0;
        if (w_acc) begin
          r_tos   <= w_tos_n;
          r_count <= w_count_n;
          if (w_is_call) r_overflow <= (r_count == c_DEPTH);
          if (w_is_ret) begin
            r_ret_valid <= 1'b1;
            r_underflow <= (r_count == '0);
            r_ret_addr  <= (r_count == '0) ? '0 : r_stack[r_tos];
          end
          if (i_ckptAlloc_1) begin
            r_used[w_free_id]     <= 1'b1;
            r_ck_tos[w_free_id]   <= w_tos_n;
            r_ck_count[w_free_id] <= w_count_n;
            r_ck_top[w_free_id]   <= w_top_n;
          end
        end
      end
    end
  end

  // Second restore cycle rewrites the top in case a post-pop CALL clobbered it.
  always_ff @(posedge fire) begin
    if (w_acc && w_is_call) begin
      r_stack[w_tos_inc] <= i_pushAddr_32;
    end else if (i_rstN && (r_state == ST_RESTORE)) begin
      r_stack[r_tos] <= r_fix_top;
    end
  end

  assign o_ckptId_2    = w_free_id;
  assign o_ckptFull_1  = w_full;
  assign o_retValid_1  = r_ret_valid;
  assign o_retAddr_32  = r_ret_addr;
  assign o_underflow_1 = r_underflow;
  assign o_overflow_1  = r_overflow;
  assign o_count_4     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_ras_ctrl.sv
//==============================================================================
// Module   : tb_ras_ctrl
// Purpose  : Directed self-checking bench for ras_ctrl.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ras_ctrl;

  logic        fire;
  logic        i_rstN;
  logic        i_valid_1;
  logic        o_ready_1;
  logic [2:0]  i_type_3;
  logic [31:0] i_pushAddr_32;
  logic        i_ckptAlloc_1;
  logic [1:0]  o_ckptId_2;
  logic        o_ckptFull_1;
  logic        i_restore_1;
  logic [1:0]  i_restoreId_2;
  logic        i_release_1;
  logic [1:0]  i_releaseId_2;
  logic        o_retValid_1;
  logic [31:0] o_retAddr_32;
  logic        o_underflow_1;
  logic        o_overflow_1;
  logic [3:0]  o_count_4;

  int n_chk;
  int n_pass;

  localparam logic [2:0] c_NORM = 3'd0;
  localparam logic [2:0] c_CALL = 3'd4;
  localparam logic [2:0] c_RET  = 3'd5;

  ras_ctrl u_dut (
    .fire          (fire),
    .i_rstN        (i_rstN),
    .i_valid_1     (i_valid_1),
    .o_ready_1     (o_ready_1),
    .i_type_3      (i_type_3),
    .i_pushAddr_32 (i_pushAddr_32),
    .i_ckptAlloc_1 (i_ckptAlloc_1),
    .o_ckptId_2    (o_ckptId_2),
    .o_ckptFull_1  (o_ckptFull_1),
    .i_restore_1   (i_restore_1),
    .i_restoreId_2 (i_restoreId_2),
    .i_release_1   (i_release_1),
    .i_releaseId_2 (i_releaseId_2),
    .o_retValid_1  (o_retValid_1),
    .o_retAddr_32  (o_retAddr_32),
    .o_underflow_1 (o_underflow_1),
    .o_overflow_1  (o_overflow_1),
    .o_count_4     (o_count_4)
  );

  initial fire = 1'b0;
  always #5 fire = ~fire;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge fire);
    #1;
  endtask

  // One request cycle; ready/id are sampled mid-cycle, before the accepting edge.
  task automatic req(input logic [2:0] t, input logic [31:0] a, input logic al,
                     output logic rdy, output logic [1:0] id);
    i_valid_1     = 1'b1;
    i_type_3      = t;
    i_pushAddr_32 = a;
    i_ckptAlloc_1 = al;
    @(negedge fire);
    rdy = o_ready_1;
    id  = o_ckptId_2;
    tick();
    i_valid_1     = 1'b0;
    i_ckptAlloc_1 = 1'b0;
    i_type_3      = c_NORM;
  endtask

  task automatic restore(input logic [1:0] id, output logic rdy);
    i_restore_1   = 1'b1;
    i_restoreId_2 = id;
    @(negedge fire);
    rdy = o_ready_1;
    tick();
    i_restore_1 = 1'b0;
  endtask

  task automatic release_id(input logic [1:0] id);
    i_release_1   = 1'b1;
    i_releaseId_2 = id;
    tick();
    i_release_1 = 1'b0;
  endtask

  task automatic ready_now(output logic rdy);
    @(negedge fire);
    rdy = o_ready_1;
  endtask

  logic       rdy;
  logic [1:0] id;

  initial begin
    n_chk = 0;
    n_pass = 0;
    i_rstN = 1'b0;
    i_valid_1 = 1'b0;
    i_type_3 = c_NORM;
    i_pushAddr_32 = '0;
    i_ckptAlloc_1 = 1'b0;
    i_restore_1 = 1'b0;
    i_restoreId_2 = '0;
    i_release_1 = 1'b0;
    i_releaseId_2 = '0;

    // Reset
    repeat (3) tick();
    chk("rst_ready", 32'(o_ready_1), 32'd0);
    chk("rst_count", 32'(o_count_4), 32'd0);
    chk("rst_retvalid", 32'(o_retValid_1), 32'd0);
    chk("rst_full", 32'(o_ckptFull_1), 32'd0);
    i_rstN = 1'b1;
    tick();
    ready_now(rdy);
    chk("post_rst_ready", 32'(rdy), 32'd1);
    tick();

    // 1: three CALLs, three RETs
    req(c_CALL, 32'h100, 1'b0, rdy, id);
    req(c_CALL, 32'h200, 1'b0, rdy, id);
    req(c_CALL, 32'h300, 1'b0, rdy, id);
    chk("t1_count3", 32'(o_count_4), 32'd3);
    req(c_RET, 32'h0, 1'b0, rdy, id);
    chk("t1_rv0", 32'(o_retValid_1), 32'd1);
    chk("t1_ret0", o_retAddr_32, 32'h300);
    chk("t1_count2", 32'(o_count_4), 32'd2);
    req(c_RET, 32'h0, 1'b0, rdy, id);
    chk("t1_ret1", o_retAddr_32, 32'h200);
    req(c_RET, 32'h0, 1'b0, rdy, id);
    chk("t1_ret2", o_retAddr_32, 32'h100);
    chk("t1_count0", 32'(o_count_4), 32'd0);
    chk("t1_uf", 32'(o_underflow_1), 32'd0);
    tick();
    chk("t1_rv_drop", 32'(o_retValid_1), 32'd0);

    // 2: overflow on the 11th CALL, then 10 RETs
    for (int i = 1; i <= 11; i++) begin
      req(c_CALL, 32'(i * 16), 1'b0, rdy, id);
      chk($sformatf("t2_ovf%0d", i), 32'(o_overflow_1), (i == 11) ? 32'd1 : 32'd0);
    end
    chk("t2_count10", 32'(o_count_4), 32'd10);
    for (int i = 11; i >= 2; i--) begin
      req(c_RET, 32'h0, 1'b0, rdy, id);
      chk($sformatf("t2_ret%0d", i), o_retAddr_32, 32'(i * 16));
    end
    chk("t2_count0", 32'(o_count_4), 32'd0);

    // 3: underflow
    req(c_RET, 32'h0, 1'b0, rdy, id);
    chk("t3_rv", 32'(o_retValid_1), 32'd1);
    chk("t3_addr", o_retAddr_32, 32'h0);
    chk("t3_uf", 32'(o_underflow_1), 32'd1);
    chk("t3_count", 32'(o_count_4), 32'd0);
    tick();

    // 4: checkpoint repairs a post-pop overwrite
    req(c_CALL, 32'hA0, 1'b1, rdy, id);
    chk("t4_alloc_rdy", 32'(rdy), 32'd1);
    chk("t4_alloc_id", 32'(id), 32'd0);
    req(c_RET, 32'h0, 1'b0, rdy, id);
    chk("t4_ret_a0", o_retAddr_32, 32'hA0);
    req(c_CALL, 32'hEE, 1'b0, rdy, id);
    restore(2'd0, rdy);
    chk("t4_rdy_c1", 32'(rdy), 32'd0);
    chk("t4_count_rest", 32'(o_count_4), 32'd1);
    ready_now(rdy);
    chk("t4_rdy_c2", 32'(rdy), 32'd0);
    tick();
    ready_now(rdy);
    chk("t4_rdy_back", 32'(rdy), 32'd1);
    chk("t4_freed", 32'(o_ckptFull_1), 32'd0);
    tick();
    req(c_RET, 32'h0, 1'b0, rdy, id);
    chk("t4_ret_repair", o_retAddr_32, 32'hA0);
    chk("t4_count0", 32'(o_count_4), 32'd0);

    // 5: fill checkpoints, stall, release, re-allocate
    for (int i = 0; i < 4; i++) begin
      req(c_NORM, 32'h0, 1'b1, rdy, id);
      chk($sformatf("t5_id%0d", i), 32'(id), 32'(i));
    end
    chk("t5_full", 32'(o_ckptFull_1), 32'd1);
    req(c_NORM, 32'h0, 1'b1, rdy, id);
    chk("t5_stall", 32'(rdy), 32'd0);
    release_id(2'd2);
    chk("t5_not_full", 32'(o_ckptFull_1), 32'd0);
    req(c_NORM, 32'h0, 1'b1, rdy, id);
    chk("t5_realloc", 32'(id), 32'd2);
    chk("t5_full2", 32'(o_ckptFull_1), 32'd1);
    for (int i = 0; i < 4; i++) release_id(2'(i));
    chk("t5_all_free", 32'(o_ckptFull_1), 32'd0);

    // 6: restore beats a same-cycle CALL; restore of a free slot does not stall
    req(c_CALL, 32'h55, 1'b0, rdy, id);
    req(c_NORM, 32'h0, 1'b1, rdy, id);
    chk("t6_id", 32'(id), 32'd0);
    i_valid_1     = 1'b1;
    i_type_3      = c_CALL;
    i_pushAddr_32 = 32'h66;
    restore(2'd0, rdy);
    i_valid_1 = 1'b0;
    i_type_3  = c_NORM;
    chk("t6_rdy", 32'(rdy), 32'd0);
    chk("t6_count", 32'(o_count_4), 32'd1);
    tick();
    req(c_RET, 32'h0, 1'b0, rdy, id);
    chk("t6_ret", o_retAddr_32, 32'h55);
    chk("t6_count0", 32'(o_count_4), 32'd0);
    restore(2'd1, rdy);
    chk("t6_free_rdy", 32'(rdy), 32'd0);
    ready_now(rdy);
    chk("t6_no_stall", 32'(rdy), 32'd1);
    chk("t6_count_keep", 32'(o_count_4), 32'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
